// File: rtl/mtl_scan_timing_gen_if.sv
// Renderer-side bus of the MTL scan timing generator: scan position out,
// registered RGB back in.
interface mtl_scan_timing_gen_if;
  logic [10:0] x_cnt;
  logic [9:0]  y_cnt;
  logic        active;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;

  modport master (output x_cnt, y_cnt, active, input red, green, blue);
  modport slave  (input x_cnt, y_cnt, active, output red, green, blue);
endinterface

// File: rtl/mtl_scan_timing_gen.sv
// Raster scan timing for the 800x480 MTL panel: counters, delay-aligned sync/DE, blanked RGB.
// Optional macro TEST_PATTERN_EN adds eight vertical colour bars selected by test_mode.
module mtl_scan_timing_gen #(
  parameter int H_ACT    = 800,
  parameter int H_FP     = 210,
  parameter int H_SYNC   = 30,
  parameter int H_BP     = 16,
  parameter int V_ACT    = 480,
  parameter int V_FP     = 22,
  parameter int V_SYNC   = 13,
  parameter int V_BP     = 10,
  parameter int PIPE_LAT = 1
) (
  input  logic                  CLK_33,
  input  logic                  reset,
  input  logic                  test_mode,
  mtl_scan_timing_gen_if.master rnd,
  output logic                  hd,
  output logic                  vd,
  output logic                  den,
  output logic [7:0]            lcd_r,
  output logic [7:0]            lcd_g,
  output logic [7:0]            lcd_b,
  output logic                  frame_tick,
  output logic [15:0]           frame_cnt
);

  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
  localparam logic [10:0] H_LAST = 11'(H_TOT - 1);
  localparam logic [10:0] H_SY   = 11'(H_SYNC);
  localparam logic [10:0] H_VS   = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_VE   = 11'(H_SYNC + H_BP + H_ACT - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOT - 1);
  localparam logic [9:0]  V_SY   = 10'(V_SYNC);
  localparam logic [9:0]  V_VS   = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_VE   = 10'(V_SYNC + V_BP + V_ACT - 1);

  logic [10:0]         x_q, x_d;
  logic [9:0]          y_q, y_d;
  logic                hs_raw, vs_raw, active;
  logic [PIPE_LAT-1:0] hs_pipe_q, hs_pipe_d;
  logic [PIPE_LAT-1:0] vs_pipe_q, vs_pipe_d;
  logic [PIPE_LAT-1:0] de_pipe_q, de_pipe_d;
  logic                hd_q, hd_d, vd_q, vd_d, den_q, den_d;
  logic [7:0]          lcd_r_q, lcd_r_d, lcd_g_q, lcd_g_d, lcd_b_q, lcd_b_d;
  logic                frame_tick_q, frame_tick_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;

`ifdef TEST_PATTERN_EN
  localparam int BAR_W = H_ACT / 8;
  logic [10:0] bar_off;
  logic [2:0]  bar_idx;
  logic [2:0]  pat_raw;
  logic [2:0]  pat_pipe_q [PIPE_LAT];
  logic [2:0]  pat_pipe_d [PIPE_LAT];
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
`endif

  always_comb begin
    x_d = x_q + 11'd1;
    y_d = y_q;
    if (x_q == H_LAST) begin
      x_d = '0;
      y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
    end

    hs_raw = (x_q >= H_SY);
    vs_raw = (y_q >= V_SY);
    active = (x_q >= H_VS) && (x_q <= H_VE) && (y_q >= V_VS) && (y_q <= V_VE);

    hs_pipe_d    = hs_pipe_q;
    vs_pipe_d    = vs_pipe_q;
    de_pipe_d    = de_pipe_q;
    hs_pipe_d[0] = hs_raw;
    vs_pipe_d[0] = vs_raw;
    de_pipe_d[0] = active;
    for (int i = 1; i < PIPE_LAT; i++) begin
      hs_pipe_d[i] = hs_pipe_q[i-1];
      vs_pipe_d[i] = vs_pipe_q[i-1];
      de_pipe_d[i] = de_pipe_q[i-1];
    end

    hd_d  = hs_pipe_q[PIPE_LAT-1];
    vd_d  = vs_pipe_q[PIPE_LAT-1];
    den_d = de_pipe_q[PIPE_LAT-1];

    lcd_r_d = '0;
    lcd_g_d = '0;
    lcd_b_d = '0;
    if (de_pipe_q[PIPE_LAT-1]) begin
      lcd_r_d = rnd.red;
      lcd_g_d = rnd.green;
      lcd_b_d = rnd.blue;
    end

`ifdef TEST_PATTERN_EN
    // Bar order white..black maps to {r,g,b} = {~idx[1], ~idx[2], ~idx[0]}
    bar_off = x_q - H_VS;
    bar_idx = 3'(bar_off / 11'(BAR_W));
    pat_raw = {~bar_idx[1], ~bar_idx[2], ~bar_idx[0]};
    pat_pipe_d[0] = pat_raw;
    for (int i = 1; i < PIPE_LAT; i++) pat_pipe_d[i] = pat_pipe_q[i-1];
    if (de_pipe_q[PIPE_LAT-1] && test_mode) begin
      lcd_r_d = {8{pat_pipe_q[PIPE_LAT-1][2]}};
      lcd_g_d = {8{pat_pipe_q[PIPE_LAT-1][1]}};
      lcd_b_d = {8{pat_pipe_q[PIPE_LAT-1][0]}};
    end
`endif

    frame_tick_d = (x_q == H_LAST) && (y_q == V_VE);
    frame_cnt_d  = frame_cnt_q + {15'd0, frame_tick_d};
  end

  always_ff @(posedge CLK_33) begin
    if (reset) begin
      x_q          <= '0;
      y_q          <= '0;
      hs_pipe_q    <= '1;
      vs_pipe_q    <= '1;
      de_pipe_q    <= '0;
      hd_q         <= 1'b1;
      vd_q         <= 1'b1;
      den_q        <= 1'b0;
      lcd_r_q      <= '0;
      lcd_g_q      <= '0;
      lcd_b_q      <= '0;
      frame_tick_q <= 1'b0;
      frame_cnt_q  <= '0;
`ifdef TEST_PATTERN_EN
      pat_pipe_q   <= '{default: '0};
`endif
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      hs_pipe_q    <= hs_pipe_d;
      vs_pipe_q    <= vs_pipe_d;
      de_pipe_q    <= de_pipe_d;
      hd_q         <= hd_d;
      vd_q         <= vd_d;
      den_q        <= den_d;
      lcd_r_q      <= lcd_r_d;
      lcd_g_q      <= lcd_g_d;
      lcd_b_q      <= lcd_b_d;
      frame_tick_q <= frame_tick_d;
      frame_cnt_q  <= frame_cnt_d;
`ifdef TEST_PATTERN_EN
      pat_pipe_q   <= pat_pipe_d;
`endif
    end
  end

  assign rnd.x_cnt  = x_q;
  assign rnd.y_cnt  = y_q;
  assign rnd.active = active;
  assign hd         = hd_q;
  assign vd         = vd_q;
  assign den        = den_q;
  assign lcd_r      = lcd_r_q;
  assign lcd_g      = lcd_g_q;
  assign lcd_b      = lcd_b_q;
  assign frame_tick = frame_tick_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
